fifo_tile_reader: RTL and testbench

- Sequences reads from one activation/weight FIFO into a systolic-array row input.
- On `start`, pulls exactly `tile_len` words from the FIFO and presents them on a valid/ready stream, then pulses `done`.
- Compensates for the FIFO's registered read port (data arrives one cycle after the read enable) with a 2-entry output skid buffer. Downstream backpressure therefore never loses data.
- Also generates the FIFO's active-low clear for flush and abort.

---
 rtl/fifo_tile_reader.sv | 182 ++++++++++++++++++
 tb/tb_fifo_tile_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tile_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_tile_reader
// Brief    : Pulls tile_len words from a registered-read FIFO and presents
//            them on a valid/ready stream through a 2-entry skid buffer.
//            Also drives the FIFO active-low clear for flush and abort.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_tile_reader #(
  parameter int DATA_SIZE = 8,
  parameter int LEN_W     = 12,
  parameter int CLR_CYC   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     tile_len,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_dout,
  output logic                 fifo_r_en,
  output logic                 fifo_clear_n,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int c_CNT_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [c_CNT_W-1:0] c_CLR_LAST = c_CNT_W'(CLR_CYC - 1);
  localparam logic [LEN_W-1:0]   c_ONE      = LEN_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_DONE  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t               r_state;
  logic [LEN_W-1:0]     r_rem_issue;
  logic                 r_inflight;
  logic [1:0]           r_occ;
  logic [DATA_SIZE-1:0] r_buf0;
  logic [DATA_SIZE-1:0] r_buf1;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_clear_n;
  logic [c_CNT_W-1:0]   r_clr_cnt;

  logic       w_pop;
  logic [2:0] w_occ_sum;
  logic [1:0] w_wr_idx;
  logic       w_rd;
  logic       w_abort;

  // Occupancy after this cycle counts the word landing from the FIFO and the
  // word leaving downstream; issuing only while it stays below 2 means the
  // skid buffer can always absorb every read already in flight.
  assign w_pop     = out_valid & out_ready;
  assign w_occ_sum = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_wr_idx  = r_occ - {1'b0, w_pop};
  assign w_rd      = (r_state == S_RUN) & ~fifo_empty &
                     (r_rem_issue != '0) & (w_occ_sum < 3'd2);
  assign w_abort   = flush & ((r_state == S_RUN) | (r_state == S_DRAIN));

  assign fifo_r_en    = w_rd;
  assign fifo_clear_n = r_clear_n;
  assign out_data     = r_buf0;
  assign out_valid    = (r_occ != 2'd0);
  assign busy         = r_busy;
  assign done         = r_done;

  // Skid buffer: head in r_buf0, capture the registered FIFO output one
  // cycle after each read, shift on pop; an abort discards everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
    end else if (w_abort) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      r_occ      <= w_occ_sum[1:0];
      if (w_pop) begin
        r_buf0 <= r_buf1;
      end
      if (r_inflight) begin
        if (w_wr_idx == 2'd0) begin
          r_buf0 <= fifo_dout;
        end else begin
          r_buf1 <= fifo_dout;
        end
      end
    end
  end

  // Tile sequencer with registered busy, done and FIFO clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rem_issue <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clear_n   <= 1'b0;
      r_clr_cnt   <= '0;
    end else begin
      r_done    <= 1'b0;
      r_clear_n <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_state   <= S_FLUSH;
            r_busy    <= 1'b1;
            r_clear_n <= 1'b0;
            r_clr_cnt <= '0;
          end else if (start) begin
            if (tile_len != '0) begin
              r_rem_issue <= tile_len;
              r_state     <= S_RUN;
              r_busy      <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            r_state     <= S_FLUSH;
            r_rem_issue <= '0;
            r_clear_n   <= 1'b0;
            r_clr_cnt   <= '0;
          end else if (w_rd) begin
            r_rem_issue <= r_rem_issue - c_ONE;
            if (r_rem_issue == c_ONE) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Finish on the edge that accepts the last buffered word.
          if (flush) begin
            r_state   <= S_FLUSH;
            r_clear_n <= 1'b0;
            r_clr_cnt <= '0;
          end else if (!r_inflight && (w_occ_sum == 3'd0)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        S_FLUSH: begin
          if (flush) begin
            r_clear_n <= 1'b0;
            r_clr_cnt <= '0;
          end else if (r_clr_cnt == c_CLR_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
            r_clear_n <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_tile_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_tile_reader
// Brief    : Scoreboard bench for fifo_tile_reader with a registered-read
//            FIFO model and directed tiles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_tile_reader;

  logic        clk        = 1'b0;
  logic        reset      = 1'b1;
  logic        start      = 1'b0;
  logic [11:0] tile_len   = '0;
  logic        flush      = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_dout  = '0;
  logic        out_ready  = 1'b0;
  logic        fifo_r_en;
  logic        fifo_clear_n;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        done;

  logic [7:0] fifo_q[$];
  logic [7:0] push_q[$];
  logic [7:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int beats    = 0;
  int ren_cnt  = 0;
  int done_cnt = 0;
  int first_beat_cyc = 0;
  int last_beat_cyc  = 0;
  int done_cyc       = 0;
  int start_cyc      = 0;
  int rd_empty_err   = 0;
  int low_cnt        = 0;
  int guard          = 0;

  fifo_tile_reader #(.DATA_SIZE(8), .LEN_W(12), .CLR_CYC(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .tile_len     (tile_len),
    .flush        (flush),
    .fifo_empty   (fifo_empty),
    .fifo_dout    (fifo_dout),
    .fifo_r_en    (fifo_r_en),
    .fifo_clear_n (fifo_clear_n),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read port, synchronous clear, pushes land at the edge.
  always @(posedge clk) begin
    if (!fifo_clear_n) begin
      fifo_q.delete();
    end else if (fifo_r_en) begin
      if (fifo_q.size() == 0) rd_empty_err++;
      else fifo_dout <= fifo_q.pop_front();
    end
    while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: compare every accepted beat against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      if (fifo_r_en) ren_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (beats == 0) first_beat_cyc = cyc;
        last_beat_cyc = cyc;
        beats++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL beat: got %h, expected no word", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data === e) n_pass++;
          else $display("FAIL beat %0d: got %h expected %h", beats, out_data, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clr_counts();
    beats = 0; ren_cnt = 0; done_cnt = 0;
  endtask

  // Push n words base, base+1, ... into the FIFO; the first nexp are expected out.
  task automatic load(input logic [7:0] base, input int n, input int nexp);
    for (int i = 0; i < n; i++) begin
      push_q.push_back(base + 8'(i));
      if (i < nexp) exp_q.push_back(base + 8'(i));
    end
  endtask

  task automatic start_tile(input logic [11:0] len);
    start = 1'b1;
    tile_len = len;
    start_cyc = cyc;
    tick(1);
    start = 1'b0;
    tile_len = 12'd3;
  endtask

  task automatic wait_done(input int budget, input string name);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin
      tick(1);
      i++;
    end
    check({name, " done pulse"}, done_cnt, 1);
  endtask

  initial begin
    // Reset values
    #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset clear_n", int'(fifo_clear_n), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset r_en", int'(fifo_r_en), 0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("clear_n after reset", int'(fifo_clear_n), 1);

    // Basic tile of 8 at full rate
    clr_counts();
    load(8'h01, 8, 8);
    out_ready = 1'b1;
    tick(2);
    start_tile(12'd8);
    wait_done(60, "basic");
    check("basic beats", beats, 8);
    check("basic r_en pulses", ren_cnt, 8);
    check("basic first latency", first_beat_cyc - start_cyc, 3);
    check("basic consecutive", last_beat_cyc - first_beat_cyc, 7);
    check("basic done timing", done_cyc - last_beat_cyc, 1);
    tick(2);
    check("basic busy idle", int'(busy), 0);
    check("basic single done", done_cnt, 1);
    check("basic scoreboard", exp_q.size(), 0);

    // Backpressure 1,0,0 pattern
    clr_counts();
    load(8'h11, 6, 6);
    tick(2);
    start_tile(12'd6);
    for (int i = 0; i < 200 && done_cnt == 0; i++) begin
      out_ready = (i % 3 == 0);
      tick(1);
    end
    out_ready = 1'b1;
    check("bp done pulse", done_cnt, 1);
    tick(2);
    check("bp beats", beats, 6);
    check("bp r_en pulses", ren_cnt, 6);
    check("bp scoreboard", exp_q.size(), 0);

    // Empty stall: 3 words available, 5 requested
    clr_counts();
    load(8'h21, 3, 3);
    tick(2);
    start_tile(12'd5);
    tick(10);
    check("stall beats", beats, 3);
    check("stall busy", int'(busy), 1);
    check("stall no done", done_cnt, 0);
    for (int i = 0; i < 2; i++) begin
      push_q.push_back(8'h24 + 8'(i));
      exp_q.push_back(8'h24 + 8'(i));
    end
    wait_done(40, "stall");
    tick(2);
    check("stall total beats", beats, 5);
    check("stall busy idle", int'(busy), 0);
    check("stall scoreboard", exp_q.size(), 0);

    // Zero length
    clr_counts();
    start_tile(12'd0);
    check("zero done next cycle", int'(done), 1);
    check("zero busy", int'(busy), 0);
    tick(1);
    check("zero done one cycle", int'(done), 0);
    tick(2);
    check("zero r_en pulses", ren_cnt, 0);
    check("zero beats", beats, 0);

    // Flush after the 5th beat of a 16-word tile
    clr_counts();
    load(8'h31, 16, 5);
    tick(2);
    start_tile(12'd16);
    guard = 0;
    while (beats < 5 && guard < 60) begin
      tick(1);
      guard++;
    end
    check("flush reach 5 beats", beats, 5);
    flush = 1'b1;
    out_ready = 1'b0;
    tick(1);
    flush = 1'b0;
    check("flush out_valid", int'(out_valid), 0);
    check("flush busy", int'(busy), 1);
    low_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (!fifo_clear_n) low_cnt++;
      tick(1);
    end
    check("flush clear_n low cycles", low_cnt, 2);
    out_ready = 1'b1;
    tick(3);
    check("flush beats", beats, 5);
    check("flush no done", done_cnt, 0);
    check("flush busy idle", int'(busy), 0);
    check("flush scoreboard", exp_q.size(), 0);

    // Asynchronous reset mid-tile
    clr_counts();
    load(8'h51, 8, 1);
    tick(2);
    start_tile(12'd8);
    tick(3);
    reset = 1'b1;
    #1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst busy", int'(busy), 0);
    check("rst clear_n", int'(fifo_clear_n), 0);
    check("rst out_data", int'(out_data), 0);
    check("rst r_en", int'(fifo_r_en), 0);
    tick(2);
    reset = 1'b0;
    check("rst clear_n held", int'(fifo_clear_n), 0);
    tick(1);
    check("rst clear_n release", int'(fifo_clear_n), 1);
    check("rst beats before", beats, 1);
    check("rst no done", done_cnt, 0);
    clr_counts();
    load(8'h61, 4, 4);
    tick(2);
    start_tile(12'd4);
    wait_done(40, "post-reset");
    tick(2);
    check("post-reset beats", beats, 4);
    check("post-reset scoreboard", exp_q.size(), 0);
    check("read on empty", rd_empty_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
